// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase enumeration and lamp decode for the traffic light controller.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_EMERG  = 2'd3
    } phase_t;

    // Only the active direction may show a non-red lamp, and only in GREEN/YELLOW.
    function automatic logic [2:0] lamp_code(input phase_t ph, input logic is_active);
        logic [2:0] code;
        code = RED;
        case (ph)
            PH_GREEN:  code = is_active ? GREEN : RED;
            PH_YELLOW: code = is_active ? YELLOW : RED;
            default:   code = RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tl_dir_arbiter.sv
// Combinational round-robin choice of the next direction to receive green.
module tl_dir_arbiter
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS = 4,
    parameter int DW       = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
    input  logic [DW-1:0]       cur_dir,
    input  logic [NUM_DIRS-1:0] req,
    input  logic                skip_en,
    output logic [DW-1:0]       next_dir
);

    logic [DW-1:0] idx_s;
    logic          found_s;

    // Search starts at cur_dir+1 and wraps, so cur_dir itself is examined last.
    always_comb begin
        next_dir = DW'((int'(cur_dir) + 1) % NUM_DIRS);
        found_s  = 1'b0;
        idx_s    = DW'(0);
        if (skip_en) begin
            for (int k = 1; k <= NUM_DIRS; k++) begin
                idx_s = DW'((int'(cur_dir) + k) % NUM_DIRS);
                if (!found_s && req[idx_s]) begin
                    next_dir = idx_s;
                    found_s  = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Parameterised multi-direction traffic light controller with skip and emergency override.
module traffic_light_ctrl_param
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS   = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_DIRS-1:0]                            req,
    input  logic                                           skip_en,
    input  logic                                           emerg,
    output logic [3*NUM_DIRS-1:0]                          lights,
    output logic [((NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1)-1:0] active_dir,
    output logic [1:0]                                     phase
);

    localparam int DW      = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
    localparam int MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
    localparam int MAX_CYC = (MAX_GY > ALLRED_CYC) ? MAX_GY : ALLRED_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] G_LOAD  = CW'(GREEN_CYC - 1);
    localparam logic [CW-1:0] Y_LOAD  = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] AR_LOAD = CW'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    phase_t        phase_r, phase_s;
    logic [DW-1:0] dir_r, dir_s, next_dir_s;
    logic [CW-1:0] cnt_r, cnt_s, cnt_dec_s;

    tl_dir_arbiter #(
        .NUM_DIRS (NUM_DIRS),
        .DW       (DW)
    ) u_arb (
        .cur_dir  (dir_r),
        .req      (req),
        .skip_en  (skip_en),
        .next_dir (next_dir_s)
    );

    assign cnt_dec_s = cnt_r - CW'(1);

    // State register; reset abandons any phase and restarts a full green on direction 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_GREEN;
            dir_r   <= DW'(0);
            cnt_r   <= G_LOAD;
        end else begin
            phase_r <= phase_s;
            dir_r   <= dir_s;
            cnt_r   <= cnt_s;
        end
    end

    // Phase sequencing; direction changes only on entry into GREEN.
    always_comb begin
        phase_s = phase_r;
        dir_s   = dir_r;
        cnt_s   = cnt_r;
        case (phase_r)
            PH_GREEN: begin
                if (emerg || (cnt_r == CNT_ZERO)) begin
                    phase_s = PH_YELLOW;
                    cnt_s   = Y_LOAD;
                end else begin
                    cnt_s = cnt_dec_s;
                end
            end
            PH_YELLOW: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_dec_s;
                end else if (emerg) begin
                    phase_s = PH_EMERG;
                    cnt_s   = CNT_ZERO;
                end else if (ALLRED_CYC > 0) begin
                    phase_s = PH_ALLRED;
                    cnt_s   = AR_LOAD;
                end else begin
                    phase_s = PH_GREEN;
                    dir_s   = next_dir_s;
                    cnt_s   = G_LOAD;
                end
            end
            PH_ALLRED: begin
                if (emerg) begin
                    phase_s = PH_EMERG;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    phase_s = PH_GREEN;
                    dir_s   = next_dir_s;
                    cnt_s   = G_LOAD;
                end else begin
                    cnt_s = cnt_dec_s;
                end
            end
            PH_EMERG: begin
                if (emerg) begin
                    cnt_s = CNT_ZERO;
                end else if (ALLRED_CYC > 0) begin
                    phase_s = PH_ALLRED;
                    cnt_s   = AR_LOAD;
                end else begin
                    phase_s = PH_GREEN;
                    dir_s   = next_dir_s;
                    cnt_s   = G_LOAD;
                end
            end
            default: begin
                phase_s = PH_GREEN;
                dir_s   = DW'(0);
                cnt_s   = G_LOAD;
            end
        endcase
    end

    // Lamp decode straight from the state register.
    always_comb begin
        lights = {(3*NUM_DIRS){1'b0}};
        for (int i = 0; i < NUM_DIRS; i++) begin
            lights[3*i +: 3] = lamp_code(phase_r, dir_r == DW'(i));
        end
    end

    assign phase      = phase_r;
    assign active_dir = dir_r;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Scoreboard bench: stimulus queues hand-derived per-cycle expectations, a negedge monitor checks them.
module tb_traffic_light_ctrl_param;

    localparam int G  = 0;
    localparam int Y  = 1;
    localparam int AR = 2;
    localparam int E  = 3;

    typedef struct {
        int ph;
        int dir;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_a;
    logic        skip_a;
    logic        emerg_a;
    logic [11:0] lights_a;
    logic [1:0]  dir_a;
    logic [1:0]  phase_a;
    logic [2:0]  req_3;
    logic        skip_3;
    logic        emerg_3;
    logic [8:0]  lights_3;
    logic [1:0]  dir_3;
    logic [1:0]  phase_3;

    exp_t qa[$];
    exp_t q3[$];
    int   checks;
    int   errors;
    logic done;
    logic end_checked;

    traffic_light_ctrl_param dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_a),
        .skip_en    (skip_a),
        .emerg      (emerg_a),
        .lights     (lights_a),
        .active_dir (dir_a),
        .phase      (phase_a)
    );

    traffic_light_ctrl_param #(
        .NUM_DIRS   (3),
        .GREEN_CYC  (8),
        .YELLOW_CYC (2),
        .ALLRED_CYC (0)
    ) dut_3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_3),
        .skip_en    (skip_3),
        .emerg      (emerg_3),
        .lights     (lights_3),
        .active_dir (dir_3),
        .phase      (phase_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] exp_lights(input int n, input int ph, input int dir);
        logic [11:0] l;
        l = 12'd0;
        for (int i = 0; i < n; i++) begin
            if (i == dir && ph == G)      l[3*i +: 3] = 3'b001;
            else if (i == dir && ph == Y) l[3*i +: 3] = 3'b010;
            else                          l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

    function automatic int non_red(input logic [11:0] l, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (l[3*i +: 3] != 3'b100) c++;
        end
        return c;
    endfunction

    task automatic step_a(input int ph, input int dir, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ph = ph;
            e.dir = dir;
            qa.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_3(input int ph, input int dir, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ph = ph;
            e.dir = dir;
            q3.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic phase_set_a(input int dir);
        step_a(G, dir, 8);
        step_a(Y, dir, 2);
        step_a(AR, dir, 1);
    endtask

    // Monitor: one expectation per cycle per DUT, plus the single-non-red invariant.
    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] el;
        logic [11:0] l3;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            el = exp_lights(4, e.ph, e.dir);
            checks++;
            if (phase_a !== 2'(e.ph) || dir_a !== 2'(e.dir) || lights_a !== el) begin
                errors++;
                $display("FAIL dut_a t=%0t: phase=%0d dir=%0d lights=%b, expected phase=%0d dir=%0d lights=%b",
                         $time, phase_a, dir_a, lights_a, e.ph, e.dir, el);
            end
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            el = exp_lights(3, e.ph, e.dir);
            checks++;
            if (phase_3 !== 2'(e.ph) || dir_3 !== 2'(e.dir) || lights_3 !== el[8:0]) begin
                errors++;
                $display("FAIL dut_3 t=%0t: phase=%0d dir=%0d lights=%b, expected phase=%0d dir=%0d lights=%b",
                         $time, phase_3, dir_3, lights_3, e.ph, e.dir, el[8:0]);
            end
        end
        l3 = {3'b100, lights_3};
        checks++;
        if (non_red(lights_a, 4) > 1 || non_red(l3, 3) > 1) begin
            errors++;
            $display("FAIL one_lit t=%0t: lights_a=%b lights_3=%b, expected at most one non-red each",
                     $time, lights_a, lights_3);
        end
        if (done && !end_checked) begin
            end_checked = 1'b1;
            checks++;
            if (qa.size() != 0 || q3.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d/%0d expectations left, expected 0/0", qa.size(), q3.size());
            end
        end
    end

    // Three-direction, no-clearance instance: free run after the shared reset.
    initial begin
        req_3   = 3'b000;
        skip_3  = 1'b0;
        emerg_3 = 1'b0;
        @(posedge clk);
        #1;
        step_3(G, 0, 2);
        for (int d = 0; d < 3; d++) begin
            step_3(G, d, 8);
            step_3(Y, d, 2);
        end
        step_3(G, 0, 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        checks      = 0;
        errors      = 0;
        done        = 1'b0;
        end_checked = 1'b0;
        rst_n   = 1'b0;
        req_a   = 4'b0000;
        skip_a  = 1'b0;
        emerg_a = 1'b0;
        @(posedge clk);
        #1;
        step_a(G, 0, 2);
        rst_n = 1'b1;

        // Free run through all four directions, then back to dir0.
        for (int d = 0; d < 4; d++) phase_set_a(d);

        // Skip mode: jump to dir3, wrap to dir0, self searched last, empty req behaves as plain.
        skip_a = 1'b1;
        req_a  = 4'b1000;
        phase_set_a(0);
        req_a  = 4'b0001;
        phase_set_a(3);
        phase_set_a(0);
        req_a  = 4'b0000;
        phase_set_a(0);

        // Emergency raised at green clock 3 for five clocks on dir1.
        skip_a = 1'b0;
        step_a(G, 1, 3);
        emerg_a = 1'b1;
        step_a(G, 1, 1);
        step_a(Y, 1, 2);
        step_a(E, 1, 2);
        emerg_a = 1'b0;
        step_a(E, 1, 1);
        step_a(AR, 1, 1);

        // Emergency only during early yellow is ignored.
        step_a(G, 2, 8);
        emerg_a = 1'b1;
        step_a(Y, 2, 1);
        emerg_a = 1'b0;
        step_a(Y, 2, 1);
        step_a(AR, 2, 1);

        // Emergency during all-red cuts straight to EMERG.
        step_a(G, 3, 8);
        step_a(Y, 3, 2);
        emerg_a = 1'b1;
        step_a(AR, 3, 1);
        emerg_a = 1'b0;
        step_a(E, 3, 1);
        step_a(AR, 3, 1);

        // Reset asserted in the middle of dir2 yellow.
        phase_set_a(0);
        phase_set_a(1);
        step_a(G, 2, 8);
        step_a(Y, 2, 1);
        e.ph = G;
        e.dir = 0;
        qa.push_back(e);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step_a(G, 0, 1);
        rst_n = 1'b1;
        step_a(G, 0, 8);
        step_a(Y, 0, 2);

        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl_param.md
TRAFFIC_LIGHT_CTRL_PARAM -- requirements
Module: traffic_light_ctrl_param

Interface
REQ-001 SHALL have parameter NUM_DIRS, default 4, number of approach directions (legal 2..8).
REQ-002 SHALL have parameter GREEN_CYC, default 8, green phase length in clocks (legal >=1).
REQ-003 SHALL have parameter YELLOW_CYC, default 2, yellow phase length in clocks (legal >=1).
REQ-004 SHALL have parameter ALLRED_CYC, default 1, all-red clearance length in clocks (legal >=0; 0 = no clearance phase).
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  NUM_DIRS  per-direction vehicle-present sensor, bit i = direction i.
REQ-008 SHALL have port skip_en  input  1  1 = skip directions with no req at phase advance.
REQ-009 SHALL have port emerg  input  1  emergency override request, level-sensitive.
REQ-010 SHALL have port lights  output  3*NUM_DIRS  lamp code per direction, bits [3i+2:3i] = direction i.
REQ-011 SHALL have port active_dir  output  max(1,$clog2(NUM_DIRS))  direction currently owning green/yellow.
REQ-012 SHALL have port phase  output  2  current phase: 0 GREEN, 1 YELLOW, 2 ALLRED, 3 EMERG.

Function
REQ-013 SHALL encode lamps as RED=3'b100, YELLOW=3'b010, GREEN=3'b001; every direction other than active_dir SHALL show RED.
REQ-014 SHALL drive lights, phase, active_dir as combinational decode of registered state; no output latency beyond the state register.
REQ-015 SHALL implement FSM GREEN, YELLOW, ALLRED, EMERG with a down-counter loaded with (length-1) on phase entry and advancing phase when counter = 0.
REQ-016 GREEN SHALL last exactly GREEN_CYC clocks, then YELLOW for exactly YELLOW_CYC clocks, active_dir unchanged.
REQ-017 After YELLOW, SHALL enter ALLRED (all RED) for ALLRED_CYC clocks; if ALLRED_CYC=0, SHALL go directly to GREEN.
REQ-018 On ALLRED->GREEN (or YELLOW->GREEN), active_dir SHALL advance to next direction: skip_en=0 -> (active_dir+1) mod NUM_DIRS.
REQ-019 With skip_en=1, next direction SHALL be the first i in round-robin order starting at active_dir+1 with req[i]=1; active_dir itself is searched last.
REQ-020 With skip_en=1 and req all zero, SHALL advance as if skip_en=0.
REQ-021 req and skip_en SHALL be sampled only in the cycle the new direction is chosen.
REQ-022 emerg=1 during GREEN SHALL force YELLOW on next clock (counter reloaded with YELLOW_CYC-1).
REQ-023 emerg=1 during YELLOW SHALL let yellow complete; emerg=1 during YELLOW-end or ALLRED SHALL go to EMERG next clock.
REQ-024 EMERG SHALL show all RED and hold while emerg=1, indefinitely.
REQ-025 emerg falling in EMERG SHALL enter ALLRED (full ALLRED_CYC, or GREEN directly if 0), then GREEN of the next direction per REQ-018..020.
REQ-026 emerg is evaluated every cycle; emerg deasserted before YELLOW ends SHALL NOT enter EMERG.

Reset
REQ-027 rst_n low SHALL immediately set phase GREEN, active_dir 0, counter GREEN_CYC-1; lights = GREEN on dir 0, RED elsewhere.
REQ-028 Reset mid-phase SHALL abandon the phase with no yellow; first GREEN after release SHALL last GREEN_CYC clocks.

Structure
REQ-029 Package traffic_pkg SHALL hold lamp constants RED/YELLOW/GREEN and enum phase_t.
REQ-030 Next-direction round-robin search SHALL be a sub-module tl_dir_arbiter (inputs current dir, req, skip_en; output next dir), purely combinational.

Verification (defaults unless stated)
REQ-031 Free-run, skip_en=0, emerg=0: dir0 G 8 clk, Y 2, AR 1, then dir1 G; full cycle 44 clocks returns to dir0 GREEN.
REQ-032 skip_en=1, req=4'b1000 at dir0 yellow end: next GREEN on dir3; req=0 -> dir1.
REQ-033 emerg pulsed high at GREEN clock 3 for 5 clocks: Y 2 clk, EMERG for remaining clocks, AR 1, then dir1 GREEN.
REQ-034 ALLRED_CYC=0, NUM_DIRS=3: Y->G directly, cycle period 30 clocks, dir sequence 0,1,2,0.
REQ-035 rst_n asserted mid-YELLOW of dir2: lights immediately dir0 GREEN; 8 GREEN clocks after release.
REQ-036 Assertion check all runs: at most one direction non-RED in any cycle.
